// File: rtl/poker_seat_controller.sv
// rtl/poker_seat_controller.sv - poker seat hand sequencer over the card-reader command interface
//
// Plays one hand per tbl_game_start: draws HAND_SIZE cards, asks the external
// evaluator for a rank, optionally discards/redraws once, re-evaluates and
// issues one betting command chosen by rank category and latched personality.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tbl_game_start/_over        table start pulse, abort/finish pulse
//   cr_cmdvld/cr_cmd/cr_wdata   card-reader command (held until cr_ack)
//   cr_ack, cr_rdata, cr_rdatavld  card-reader accept and card return
//   personality, bluff_thresh   betting style and bluff threshold, latched at start
//   eval_req/eval_hand          evaluation request pulse and packed hand
//   eval_rank/eval_keep/eval_vld   evaluation result
//   hand_rank_out, action_out   last captured rank, last issued betting command
//   busy, timeout_err           not-idle flag, sticky handshake timeout
module poker_seat_controller #(
    parameter int CARD_W      = 6,
    parameter int HAND_SIZE   = 5,
    parameter int RANK_W      = 9,
    parameter int MAX_DISCARD = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tbl_game_start,
    input  logic                        tbl_game_over,
    output logic                        cr_cmdvld,
    output logic [2:0]                  cr_cmd,
    output logic [CARD_W-1:0]           cr_wdata,
    input  logic                        cr_ack,
    input  logic [7:0]                  cr_rdata,
    input  logic                        cr_rdatavld,
    input  logic [1:0]                  personality,
    input  logic [RANK_W-1:0]           bluff_thresh,
    output logic                        eval_req,
    output logic [HAND_SIZE*CARD_W-1:0] eval_hand,
    input  logic [RANK_W-1:0]           eval_rank,
    input  logic [HAND_SIZE-1:0]        eval_keep,
    input  logic                        eval_vld,
    output logic [RANK_W-1:0]           hand_rank_out,
    output logic [2:0]                  action_out,
    output logic                        busy,
    output logic                        timeout_err
);
    localparam int SW = (HAND_SIZE > 1) ? $clog2(HAND_SIZE) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] CMD_DRAW  = 3'b001;
    localparam logic [2:0] CMD_DISC  = 3'b010;
    localparam logic [2:0] CMD_CHECK = 3'b011;
    localparam logic [2:0] CMD_RAISE = 3'b100;
    localparam logic [2:0] CMD_FOLD  = 3'b101;
    localparam logic [2:0] CMD_CALL  = 3'b110;

    localparam logic [1:0] P_CONS  = 2'b00;
    localparam logic [1:0] P_BLUFF = 2'b10;
    localparam logic [1:0] P_AGG   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_DRAW_CMD, S_DRAW_DATA, S_EVAL_REQ, S_EVAL_WAIT,
        S_DECIDE, S_DISC_CMD, S_ACT_CMD, S_DONE
    } state_t;

    state_t                state_q, state_nx;
    logic [SW-1:0]         slot_q, slot_nx;
    logic [HAND_SIZE-1:0]  mask_q, mask_nx;     // slots still to draw / discard
    logic [HAND_SIZE-1:0]  keep_q, disc_mask;
    logic [1:0]            pers_q;
    logic [RANK_W-1:0]     thresh_q;
    logic [CW-1:0]         wait_q;
    logic                  redraw_q, card_got_q;
    logic                  start, take_card, capture_eval, cmd_acc, act_done;
    logic                  redraw_set, wait_inc, timeout;
    logic                  cmdvld_nx;
    logic [2:0]            cmd_nx, act_cmd;
    logic [CARD_W-1:0]     wdata_nx, act_wdata;
    logic [SW:0]           nxt, first_disc;
    logic [3:0]            cat;
    int                    disc_cnt;

    // Lowest set bit of m above cur (or at cur when incl); MSB flags "found".
    function automatic logic [SW:0] find_next(input logic [HAND_SIZE-1:0] m,
                                              input logic [SW-1:0] cur,
                                              input logic incl);
        find_next = '0;
        for (int i = HAND_SIZE - 1; i >= 0; i--)
            if (m[i] && ((i > int'(cur)) || (incl && (i == int'(cur)))))
                find_next = {1'b1, SW'(i)};
    endfunction

    assign cat = hand_rank_out[RANK_W-1 -: 4];

    // Discard candidates: lowest-indexed non-contributing cards, capped.
    always_comb begin
        disc_mask = '0;
        disc_cnt  = 0;
        for (int i = 0; i < HAND_SIZE; i++) begin
            if (!keep_q[i] && (disc_cnt < MAX_DISCARD)) begin
                disc_mask[i] = 1'b1;
                disc_cnt++;
            end
        end
        first_disc = find_next(disc_mask, '0, 1'b1);
    end

    always_comb begin
        act_cmd   = CMD_CALL;
        act_wdata = '0;
        if (cat >= 4'd6) begin
            act_cmd   = CMD_RAISE;
            act_wdata = CARD_W'(3);
        end else if (cat >= 4'd3) begin
            if (pers_q == P_AGG) begin
                act_cmd   = CMD_RAISE;
                act_wdata = CARD_W'(1);
            end
        end else if (cat >= 4'd1) begin
            if (pers_q == P_CONS) act_cmd = CMD_CHECK;
        end else begin
            case (pers_q)
                P_BLUFF: begin
                    if (hand_rank_out >= thresh_q) begin
                        act_cmd   = CMD_RAISE;
                        act_wdata = CARD_W'(2);
                    end else begin
                        act_cmd = CMD_FOLD;
                    end
                end
                P_CONS:  act_cmd = CMD_FOLD;
                default: act_cmd = CMD_CHECK;
            endcase
        end
    end

    always_comb begin
        state_nx     = state_q;
        slot_nx      = slot_q;
        mask_nx      = mask_q;
        start        = 1'b0;
        take_card    = 1'b0;
        capture_eval = 1'b0;
        cmd_acc      = 1'b0;
        act_done     = 1'b0;
        redraw_set   = 1'b0;
        wait_inc     = 1'b0;
        timeout      = 1'b0;
        nxt          = '0;
        case (state_q)
            S_IDLE: begin
                if (tbl_game_start && !tbl_game_over) begin
                    start    = 1'b1;
                    slot_nx  = '0;
                    mask_nx  = '1;
                    state_nx = S_DRAW_CMD;
                end
            end
            S_DRAW_CMD: begin
                if (cr_cmdvld) begin
                    if (cr_ack) begin
                        cmd_acc   = 1'b1;
                        take_card = cr_rdatavld;
                        state_nx  = S_DRAW_DATA;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
            end
            S_DRAW_DATA: begin
                // A card already taken in the ack cycle still passes through
                // here, which also provides the gap before the next command.
                if (card_got_q || cr_rdatavld) begin
                    take_card = !card_got_q;
                    nxt       = find_next(mask_q, slot_q, 1'b0);
                    if (nxt[SW]) begin
                        slot_nx  = nxt[SW-1:0];
                        state_nx = S_DRAW_CMD;
                    end else begin
                        state_nx = S_EVAL_REQ;
                    end
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_EVAL_REQ: state_nx = S_EVAL_WAIT;
            S_EVAL_WAIT: begin
                if (eval_vld) begin
                    capture_eval = 1'b1;
                    state_nx     = S_DECIDE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECIDE: begin
                if ((MAX_DISCARD > 0) && !redraw_q && (cat <= 4'd2) && !(&keep_q)) begin
                    mask_nx  = disc_mask;
                    slot_nx  = first_disc[SW-1:0];
                    state_nx = S_DISC_CMD;
                end else begin
                    state_nx = S_ACT_CMD;
                end
            end
            S_DISC_CMD: begin
                if (cr_cmdvld) begin
                    if (cr_ack) begin
                        cmd_acc = 1'b1;
                        nxt     = find_next(mask_q, slot_q, 1'b0);
                        if (nxt[SW]) begin
                            slot_nx = nxt[SW-1:0];
                        end else begin
                            redraw_set = 1'b1;
                            nxt        = find_next(mask_q, '0, 1'b1);
                            slot_nx    = nxt[SW-1:0];
                            state_nx   = S_DRAW_CMD;
                        end
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
            end
            S_ACT_CMD: begin
                if (cr_cmdvld) begin
                    if (cr_ack) begin
                        cmd_acc  = 1'b1;
                        act_done = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
            end
            S_DONE: if (tbl_game_over) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        if (wait_inc && (wait_q == CW'(TIMEOUT - 1))) begin
            timeout  = 1'b1;
            state_nx = S_IDLE;
        end

        // Abort wins over everything, including an ack or result this cycle.
        if ((state_q != S_IDLE) && tbl_game_over) begin
            state_nx     = S_IDLE;
            take_card    = 1'b0;
            capture_eval = 1'b0;
            act_done     = 1'b0;
            redraw_set   = 1'b0;
            timeout      = 1'b0;
        end

        // An accepted command always drops valid for one cycle.
        cmdvld_nx = ((state_nx == S_DRAW_CMD) || (state_nx == S_DISC_CMD) ||
                     (state_nx == S_ACT_CMD)) && !cmd_acc;
        cmd_nx    = CMD_DRAW;
        wdata_nx  = CARD_W'(slot_nx);
        if (state_nx == S_DISC_CMD) begin
            cmd_nx = CMD_DISC;
        end else if (state_nx == S_ACT_CMD) begin
            cmd_nx   = act_cmd;
            wdata_nx = act_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            slot_q        <= '0;
            mask_q        <= '0;
            keep_q        <= '0;
            pers_q        <= '0;
            thresh_q      <= '0;
            wait_q        <= '0;
            redraw_q      <= 1'b0;
            card_got_q    <= 1'b0;
            cr_cmdvld     <= 1'b0;
            cr_cmd        <= '0;
            cr_wdata      <= '0;
            eval_req      <= 1'b0;
            eval_hand     <= '0;
            hand_rank_out <= '0;
            action_out    <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state_q    <= state_nx;
            slot_q     <= slot_nx;
            mask_q     <= mask_nx;
            card_got_q <= (state_q == S_DRAW_CMD) && take_card;
            if ((state_nx != state_q) || cmd_acc) wait_q <= '0;
            else if (wait_inc)                    wait_q <= wait_q + 1'b1;
            cr_cmdvld <= cmdvld_nx;
            if (cmdvld_nx) begin
                cr_cmd   <= cmd_nx;
                cr_wdata <= wdata_nx;
            end
            eval_req <= (state_nx == S_EVAL_REQ);
            busy     <= (state_nx != S_IDLE);
            if (start) begin
                eval_hand   <= '0;
                redraw_q    <= 1'b0;
                action_out  <= '0;
                timeout_err <= 1'b0;
                pers_q      <= personality;
                thresh_q    <= bluff_thresh;
            end
            if (take_card)    eval_hand[slot_q*CARD_W +: CARD_W] <= cr_rdata[CARD_W-1:0];
            if (capture_eval) begin
                hand_rank_out <= eval_rank;
                keep_q        <= eval_keep;
            end
            if (redraw_set) redraw_q    <= 1'b1;
            if (act_done)   action_out  <= cr_cmd;
            if (timeout)    timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_poker_seat_controller.sv
// tb/tb_poker_seat_controller.sv - directed self-checking bench for poker_seat_controller
module tb_poker_seat_controller;
    localparam int CARD_W = 6, HAND_SIZE = 5, RANK_W = 12, MAX_DISCARD = 3, TIMEOUT = 15;
    localparam logic [1:0] P_CONS = 2'b00, P_NORM = 2'b01, P_BLUFF = 2'b10, P_AGG = 2'b11;

    logic clk = 0, rst = 1, tbl_game_start = 0, tbl_game_over = 0;
    logic cr_cmdvld, cr_ack = 0, cr_rdatavld = 0, eval_req, eval_vld = 0, busy, timeout_err;
    logic [2:0] cr_cmd, action_out;
    logic [CARD_W-1:0] cr_wdata;
    logic [7:0] cr_rdata = 0;
    logic [1:0] personality = 0;
    logic [RANK_W-1:0] bluff_thresh = 0, eval_rank = 0, hand_rank_out;
    logic [HAND_SIZE*CARD_W-1:0] eval_hand;
    logic [HAND_SIZE-1:0] eval_keep = 0;

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, act_ack_cyc = 0, log_n = 0, eval_n = 0, draw_cnt = 0;
    int no_ack_at = -1, gap_viol = 0;
    bit same_cycle = 0, eval_en = 1, data_pending = 0, eval_pending = 0, prev_ack = 0, act_seen = 0;
    logic [2:0] cmd_log[64];
    logic [CARD_W-1:0] wd_log[64];
    logic [RANK_W-1:0] ranks[4];
    logic [HAND_SIZE-1:0] keeps[4];
    logic [HAND_SIZE*CARD_W-1:0] hand_snap[4];

    poker_seat_controller #(.CARD_W(CARD_W), .HAND_SIZE(HAND_SIZE), .RANK_W(RANK_W),
                            .MAX_DISCARD(MAX_DISCARD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .tbl_game_start(tbl_game_start), .tbl_game_over(tbl_game_over),
        .cr_cmdvld(cr_cmdvld), .cr_cmd(cr_cmd), .cr_wdata(cr_wdata), .cr_ack(cr_ack),
        .cr_rdata(cr_rdata), .cr_rdatavld(cr_rdatavld), .personality(personality),
        .bluff_thresh(bluff_thresh), .eval_req(eval_req), .eval_hand(eval_hand),
        .eval_rank(eval_rank), .eval_keep(eval_keep), .eval_vld(eval_vld),
        .hand_rank_out(hand_rank_out), .action_out(action_out), .busy(busy),
        .timeout_err(timeout_err));

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Card reader and evaluator responders: ack every command in its first
    // valid cycle, return card data either with the ack or one cycle later.
    initial forever begin
        @(negedge clk);
        cr_ack = 0; cr_rdatavld = 0; eval_vld = 0;
        if (rst) begin
            data_pending = 0; eval_pending = 0; prev_ack = 0;
        end else begin
            if (cr_cmdvld && prev_ack) gap_viol++;
            prev_ack = 0;
            if (data_pending) begin
                cr_rdatavld = 1; cr_rdata = 8'hC0 | 8'(10 + draw_cnt); draw_cnt++; data_pending = 0;
            end
            if (cr_cmdvld && (log_n != no_ack_at)) begin
                cr_ack = 1; prev_ack = 1;
                if (log_n < 64) begin cmd_log[log_n] = cr_cmd; wd_log[log_n] = cr_wdata; end
                log_n++;
                if (cr_cmd >= 3'b011) begin act_seen = 1; act_ack_cyc = cyc; end
                if (cr_cmd == 3'b001) begin
                    if (same_cycle) begin
                        cr_rdatavld = 1; cr_rdata = 8'hC0 | 8'(10 + draw_cnt); draw_cnt++;
                    end else begin
                        data_pending = 1;
                    end
                end
            end
            if (eval_pending && eval_en && eval_n >= 1 && eval_n <= 4) begin
                eval_vld = 1; eval_rank = ranks[eval_n-1]; eval_keep = keeps[eval_n-1];
            end
            eval_pending = 0;
            if (eval_req) begin
                if (eval_n < 4) hand_snap[eval_n] = eval_hand;
                eval_n++; eval_pending = 1;
            end
        end
    end

    task automatic start_hand(input logic [1:0] pers, input logic [RANK_W-1:0] thr,
                              input bit same, input int noack);
        log_n = 0; eval_n = 0; draw_cnt = 0; act_seen = 0;
        no_ack_at = noack; same_cycle = same; eval_en = 1;
        personality = pers; bluff_thresh = thr;
        @(negedge clk); tbl_game_start = 1; start_cyc = cyc;
        @(negedge clk); tbl_game_start = 0;
    endtask

    task automatic wait_action();
        int n = 0;
        while (!act_seen && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (!act_seen) begin failures++; $display("FAIL action_wait: no betting command within %0d cycles", n); end
        @(negedge clk);
    endtask

    task automatic end_hand();
        @(negedge clk); tbl_game_over = 1;
        @(negedge clk); tbl_game_over = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++; if (cr_cmdvld !== 1'b0) begin failures++; $display("FAIL reset_cmdvld: got %b want 0", cr_cmdvld); end
        checks++; if (cr_cmd !== 3'b0) begin failures++; $display("FAIL reset_cmd: got %b want 000", cr_cmd); end
        checks++; if (cr_wdata !== '0) begin failures++; $display("FAIL reset_wdata: got %0h want 0", cr_wdata); end
        checks++; if (eval_req !== 1'b0) begin failures++; $display("FAIL reset_eval_req: got %b want 0", eval_req); end
        checks++; if (eval_hand !== '0) begin failures++; $display("FAIL reset_eval_hand: got %0h want 0", eval_hand); end
        checks++; if (hand_rank_out !== '0) begin failures++; $display("FAIL reset_rank: got %0h want 0", hand_rank_out); end
        checks++; if (action_out !== 3'b0) begin failures++; $display("FAIL reset_action: got %b want 000", action_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_high_hand();
        logic [HAND_SIZE*CARD_W-1:0] exp_hand;
        int bad;
        exp_hand = '0;
        for (int i = 0; i < HAND_SIZE; i++) exp_hand[i*CARD_W +: CARD_W] = CARD_W'(10 + i);
        ranks[0] = 12'h7A5; keeps[0] = 5'b11111;
        start_hand(P_NORM, '0, 0, -1);
        wait_action();
        bad = 0;
        for (int i = 0; i < 5; i++) if (cmd_log[i] !== 3'b001 || wd_log[i] !== CARD_W'(i)) bad++;
        checks++; if (log_n != 6) begin failures++; $display("FAIL high_cmd_count: got %0d want 6", log_n); end
        checks++; if (bad != 0) begin failures++; $display("FAIL high_draw_seq: %0d bad entries want DRAW 0..4", bad); end
        checks++; if (cmd_log[5] !== 3'b100 || wd_log[5] !== 6'd3) begin failures++; $display("FAIL high_bet: got cmd %b wdata %0d want 100/3", cmd_log[5], wd_log[5]); end
        checks++; if (eval_n != 1) begin failures++; $display("FAIL high_eval_count: got %0d want 1", eval_n); end
        checks++; if (action_out !== 3'b100) begin failures++; $display("FAIL high_action: got %b want 100", action_out); end
        checks++; if (hand_rank_out !== 12'h7A5) begin failures++; $display("FAIL high_rank: got %0h want 7a5", hand_rank_out); end
        checks++; if (hand_snap[0] !== exp_hand) begin failures++; $display("FAIL high_hand: got %0h want %0h", hand_snap[0], exp_hand); end
        checks++; if (act_ack_cyc - start_cyc != 14) begin failures++; $display("FAIL high_latency: got %0d want 14", act_ack_cyc - start_cyc); end
        end_hand();
    endtask

    task automatic test_redraw();
        logic [2:0] ec[12] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
                               3'b001, 3'b001, 3'b001, 3'b110};
        int ew[12] = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 0};
        logic [HAND_SIZE*CARD_W-1:0] exp_hand;
        int bad;
        exp_hand = {6'd17, 6'd16, 6'd15, 6'd11, 6'd10};
        ranks[0] = 12'h005; keeps[0] = 5'b00011;
        ranks[1] = 12'h100; keeps[1] = 5'b00001;
        start_hand(P_NORM, '0, 1, -1);
        wait_action();
        bad = 0;
        for (int i = 0; i < 12; i++) if (cmd_log[i] !== ec[i] || wd_log[i] !== CARD_W'(ew[i])) bad++;
        checks++; if (log_n != 12) begin failures++; $display("FAIL redraw_cmd_count: got %0d want 12", log_n); end
        checks++; if (bad != 0) begin failures++; $display("FAIL redraw_seq: %0d bad entries", bad); end
        checks++; if (eval_n != 2) begin failures++; $display("FAIL redraw_eval_count: got %0d want 2", eval_n); end
        checks++; if (action_out !== 3'b110) begin failures++; $display("FAIL redraw_action: got %b want 110", action_out); end
        checks++; if (hand_rank_out !== 12'h100) begin failures++; $display("FAIL redraw_rank: got %0h want 100", hand_rank_out); end
        checks++; if (hand_snap[1] !== exp_hand) begin failures++; $display("FAIL redraw_hand: got %0h want %0h", hand_snap[1], exp_hand); end
        end_hand();
    endtask

    task automatic test_personality();
        logic [1:0] bp[4] = '{P_BLUFF, P_BLUFF, P_CONS, P_AGG};
        logic [RANK_W-1:0] br[4] = '{12'h01F, 12'h020, 12'h150, 12'h4FF};
        logic [2:0] bc[4] = '{3'b101, 3'b100, 3'b011, 3'b100};
        int bw[4] = '{0, 2, 0, 1};
        for (int k = 0; k < 4; k++) begin
            ranks[0] = br[k]; keeps[0] = 5'b11111;
            start_hand(bp[k], 12'h020, 0, -1);
            wait_action();
            checks++; if (action_out !== bc[k]) begin failures++; $display("FAIL pers_action_%0d: got %b want %b", k, action_out, bc[k]); end
            checks++; if (wd_log[log_n-1] !== CARD_W'(bw[k])) begin failures++; $display("FAIL pers_wdata_%0d: got %0d want %0d", k, wd_log[log_n-1], bw[k]); end
            end_hand();
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit bet = 0;
        start_hand(P_NORM, '0, 0, -1);
        eval_en = 0;
        while (!eval_req && n < 100) begin @(negedge clk); n++; end
        checks++; if (!eval_req) begin failures++; $display("FAIL to_eval_req: no eval_req within %0d cycles", n); end
        repeat (15) @(negedge clk);
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_early: got busy %b err %b want 1/0", busy, timeout_err); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", timeout_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy: got %b want 0", busy); end
        for (int i = 0; i < log_n && i < 64; i++) if (cmd_log[i] >= 3'b011) bet = 1;
        checks++; if (bet || action_out !== 3'b000) begin failures++; $display("FAIL to_no_bet: action %b bet_seen %0d want 000/0", action_out, bet); end
        eval_en = 1;
    endtask

    task automatic test_game_over();
        int n = 0;
        start_hand(P_NORM, '0, 0, 2);
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL go_err_clear: got %b want 0", timeout_err); end
        while (!(cr_cmdvld && cr_cmd == 3'b001 && cr_wdata == 6'd2) && n < 100) begin @(negedge clk); n++; end
        checks++; if (!(cr_cmdvld && cr_wdata == 6'd2)) begin failures++; $display("FAIL go_third_draw: not seen within %0d cycles", n); end
        tbl_game_over = 1;
        @(negedge clk); tbl_game_over = 0;
        checks++; if (cr_cmdvld !== 1'b0) begin failures++; $display("FAIL go_cmdvld: got %b want 0", cr_cmdvld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL go_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || cr_cmdvld !== 1'b0) begin failures++; $display("FAIL go_stay_idle: busy %b cmdvld %b want 0/0", busy, cr_cmdvld); end
        ranks[0] = 12'h7A5; keeps[0] = 5'b11111;
        start_hand(P_NORM, '0, 0, -1);
        wait_action();
        checks++; if (cmd_log[0] !== 3'b001 || wd_log[0] !== 6'd0 || log_n != 6) begin failures++; $display("FAIL go_restart: first cmd %b wdata %0d count %0d want 001/0/6", cmd_log[0], wd_log[0], log_n); end
        end_hand();
    endtask

    task automatic test_start_with_over();
        @(negedge clk); tbl_game_start = 1; tbl_game_over = 1;
        @(negedge clk); tbl_game_start = 0; tbl_game_over = 0;
        checks++; if (busy !== 1'b0 || cr_cmdvld !== 1'b0) begin failures++; $display("FAIL both_idle: busy %b cmdvld %b want 0/0", busy, cr_cmdvld); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL both_idle_hold: busy %b want 0", busy); end
    endtask

    task automatic test_rst_in_discard();
        int n = 0;
        ranks[0] = 12'h005; keeps[0] = 5'b00011;
        start_hand(P_NORM, '0, 0, -1);
        while (!(cr_cmdvld && cr_cmd == 3'b010) && n < 100) begin @(negedge clk); n++; end
        checks++; if (!(cr_cmdvld && cr_cmd == 3'b010)) begin failures++; $display("FAIL rst_disc_seen: no DISCARD within %0d cycles", n); end
        rst = 1;
        @(negedge clk);
        checks++; if (cr_cmdvld !== 1'b0 || cr_cmd !== 3'b0 || cr_wdata !== '0) begin failures++; $display("FAIL rst_cmd_outputs: vld %b cmd %b wdata %0h want 0", cr_cmdvld, cr_cmd, cr_wdata); end
        checks++; if (eval_req !== 1'b0 || eval_hand !== '0) begin failures++; $display("FAIL rst_eval_outputs: req %b hand %0h want 0", eval_req, eval_hand); end
        checks++; if (hand_rank_out !== '0 || action_out !== 3'b0) begin failures++; $display("FAIL rst_result_outputs: rank %0h action %b want 0", hand_rank_out, action_out); end
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_status: busy %b err %b want 0", busy, timeout_err); end
        rst = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_high_hand();
        test_redraw();
        test_personality();
        test_timeout();
        test_game_over();
        test_start_with_over();
        test_rst_in_discard();
        checks++; if (gap_viol != 0) begin failures++; $display("FAIL cmd_gap: %0d back-to-back valid cycles want 0", gap_viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
